load_store_initiator: RTL and testbench
=======================================

Name: load_store_initiator

Overview:
- Pipeline memory-stage initiator. Accepts one instruction per handshake from execute (IR, effective address A, store data B, PC).
- Issues load/store transactions over a valid/ready request and response bus to a word-organised data memory with variable latency, with byte enables.
- Splits word-crossing misaligned accesses into two beats. Assembles and sign- or zero-extends load data.
- Presents IR/RD/A/PC to writeback with a one-cycle out_valid pulse.

Parameters:
- ADDR_W, 16, width of word index on req_addr. The memory holds 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  block can accept; high only in IDLE
- IR  in  32  instruction
- A  in  32  effective byte address
- B  in  32  store data
- PC  in  32  instruction PC
- req_valid  out  1  bus request valid
- req_ready  in  1  memory accepts request
- req_we  out  1  1 = store beat, 0 = load beat
- req_addr  out  ADDR_W  word index
- req_be  out  4  byte-lane enables, bit n = bits 8n+7:8n
- req_wdata  out  32  lane-aligned store data
- rsp_valid  in  1  response or store acknowledge, one per accepted request
- rsp_rdata  in  32  read word; ignored for stores
- out_valid  out  1  one-cycle pulse, results valid
- IR_out  out  32  captured IR
- RD_out  out  32  extended load data; 0 for non-loads
- A_out  out  32  captured A
- PC_out  out  32  captured PC

Behaviour:
- Reset (async, rst_n low) values:
  - state IDLE; req_valid 0, out_valid 0.
  - IR_out, RD_out, A_out, PC_out, req_addr, req_be, req_wdata all 0; req_we 0.
  - Reset mid-transaction abandons it: no further beats, no out_valid. Late rsp_valid after reset is ignored.
- Decode at acceptance (in_valid & in_ready):
  - load: opcode 0000011
  - store: opcode 0100011
  - size from IR[14:12]:
    - loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
    - stores: 0 SB, 1 SH, 2 SW
    - any other funct3 is illegal.
- Non-memory or illegal instructions:
  - no bus activity; state goes to DONE.
  - out_valid asserts the next cycle with RD_out = 0.
- Lane arithmetic:
  - off = A[1:0], n = 1/2/4 bytes.
  - Beat0 lanes are off to min(off+n-1, 3), at word A[ADDR_W+1:2].
  - If off+n > 4, beat1 covers lanes 0 to off+n-5, at word index +1. The index wraps modulo 2^ADDR_W.
  - Store data is B rotated left by 8*off bits. Each beat drives the full rotated word on req_wdata; only enabled lanes are meaningful.
- States:
  - IDLE: accept a memory op → REQ (beat 0).
  - REQ: req_valid high; req_addr/be/we/wdata stable until req_ready. On req_valid & req_ready → WAIT.
  - WAIT: on rsp_valid, a load captures the enabled lanes of rsp_rdata into a 32-bit assembly register. If beat1 is pending → REQ (beat 1), otherwise → DONE.
  - DONE: out_valid = 1 for exactly one cycle, then → IDLE.
- Stores wait for the rsp_valid acknowledge of each beat.
- rsp_valid outside WAIT is ignored.
- RD_out:
  - assembled bytes are right-justified to the access size.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - stores: RD_out = 0.
- IR_out/A_out/PC_out are captured at acceptance and update only then.
- Zero-wait memory (req_ready = 1, rsp_valid the cycle after acceptance), aligned access:
  - accept at cycle 0
  - req_valid at cycle 1
  - rsp at cycle 2
  - out_valid at cycle 3
- A split access adds 2 cycles.
- A non-memory op gives out_valid at cycle 1.
- in_ready = (state == IDLE); no new acceptance during DONE.

Decomposition:
- Shared package lsu_pkg:
  - opcode constants OP_LOAD, OP_STORE
  - funct3 constants F3_B/H/W/BU/HU
  - state enum IDLE/REQ/WAIT/DONE
- Sub-module lsu_lane_align (combinational): from off, size, B and beat, produces be, wdata and the beat1-needed flag.
- Extraction and extension stay in the top.

Test Plan:
- LW A=0x100, memory returns 0xDEADBEEF, zero-wait → req_addr 0x40, be 1111; out_valid at cycle 3 with RD_out 0xDEADBEEF, A_out 0x100.
- LB A=0x103, rsp_rdata 0x80AABBCC → be 1000, RD_out 0xFFFFFF80. Same stimulus as LBU → RD_out 0x00000080.
- SW A=0x102, B=0x11223344:
  - beat0: addr 0x40, be 1100, wdata 0x33441122
  - beat1: addr 0x41, be 0011, wdata 0x33441122
  - out_valid after 2nd ack, RD_out 0.
- LH A=0x3FFFF (ADDR_W=16), beat0 rdata 0x7F000000, beat1 rdata 0x00000001:
  - beat1 addr wraps to 0x0000, be 0001
  - RD_out 0x0000017F
- ADD (opcode 0110011) → no req_valid; out_valid at cycle 1 with RD_out 0, IR_out = IR. Separately: hold req_ready low for 5 cycles → req_* stable, in_ready low throughout.
- rst_n low during WAIT of an LW → req_valid/out_valid 0 immediately, in_ready 1 after release. A stray rsp_valid then causes no out_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the memory-stage load/store initiator.
// Opcodes, funct3 size codes and the controller state encoding.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Sign- or zero-extend right-justified load data according to funct3.
    function automatic logic [31:0] extend_load(input logic [31:0] v, input logic [2:0] f3);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{v[7]}}, v[7:0]};
            F3_H:    r = {{16{v[15]}}, v[15:0]};
            F3_BU:   r = {24'd0, v[7:0]};
            F3_HU:   r = {16'd0, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane arithmetic for one access: lane enables of the requested beat,
// rotated store data, and whether the access spills into a second word.
module lsu_lane_align (
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] b,
    input  logic        beat,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        need_beat1
);

    logic [3:0] base;
    logic [7:0] span;

    always_comb begin
        base = 4'b1111;
        case (size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        // Lanes of both beats in one 8-bit window: low nibble beat 0, high nibble beat 1.
        span       = {4'b0000, base} << off;
        be         = beat ? span[7:4] : span[3:0];
        need_beat1 = |span[7:4];

        wdata = b;
        case (off)
            2'd1:    wdata = {b[23:0], b[31:24]};
            2'd2:    wdata = {b[15:0], b[31:16]};
            2'd3:    wdata = {b[7:0],  b[31:8]};
            default: wdata = b;
        endcase
    end

endmodule

// File: rtl/load_store_initiator.sv
// Memory-stage initiator: one load/store per accepted instruction, split into
// up to two bus beats, with load data assembly and extension for writeback.
module load_store_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       IR,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic [31:0]       PC,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        req_be,
    output logic [31:0]       req_wdata,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_rdata,
    output logic              out_valid,
    output logic [31:0]       IR_out,
    output logic [31:0]       RD_out,
    output logic [31:0]       A_out,
    output logic [31:0]       PC_out
);

    state_t              state_q, state_d;
    logic [31:0]         ir_q, ir_d, a_q, a_d, pc_q, pc_d, rd_q, rd_d;
    logic [31:0]         asm_q, asm_d;
    logic [2:0]          f3_q, f3_d;
    logic                split_q, split_d;
    logic                req_valid_q, req_valid_d, req_we_q, req_we_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [3:0]          req_be_q, req_be_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic                out_valid_q, out_valid_d;

    logic [2:0]  f3;
    logic        is_load, is_store;
    logic        idle;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic        la_need_beat1;
    logic [63:0] rot64;
    logic [7:0]  be8;
    logic [31:0] asm_merge;

    assign f3       = IR[14:12];
    assign is_load  = (IR[6:0] == OP_LOAD)  && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign is_store = (IR[6:0] == OP_STORE) && (f3 inside {F3_B, F3_H, F3_W});
    assign idle     = (state_q == IDLE);

    // In IDLE the aligner sees the incoming access; afterwards the captured one, beat 1.
    lsu_lane_align u_align (
        .off        (idle ? A[1:0]  : a_q[1:0]),
        .size       (idle ? f3[1:0] : f3_q[1:0]),
        .b          (B),
        .beat       (!idle),
        .be         (la_be),
        .wdata      (la_wdata),
        .need_beat1 (la_need_beat1)
    );

    // Rotating the read word right by the offset puts every enabled lane at its
    // final byte position, for beat 0 and beat 1 alike.
    always_comb begin
        rot64 = {rsp_rdata, rsp_rdata} >> {a_q[1:0], 3'b000};
        be8   = {req_be_q, req_be_q} >> a_q[1:0];
        for (int k = 0; k < 4; k++) begin
            asm_merge[8*k +: 8] = be8[k] ? rot64[8*k +: 8] : asm_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        a_d         = a_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        asm_d       = asm_q;
        f3_d        = f3_q;
        split_d     = split_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_be_d    = req_be_q;
        req_wdata_d = req_wdata_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ir_d  = IR;
                    a_d   = A;
                    pc_d  = PC;
                    f3_d  = f3;
                    asm_d = 32'd0;
                    if (is_load || is_store) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_we_d    = is_store;
                        req_addr_d  = A[ADDR_W+1:2];
                        req_be_d    = la_be;
                        req_wdata_d = la_wdata;
                        split_d     = la_need_beat1;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        rd_d        = 32'd0;
                    end
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (!req_we_q) asm_d = asm_merge;
                    if (split_q) begin
                        state_d     = REQ;
                        split_d     = 1'b0;
                        req_valid_d = 1'b1;
                        req_addr_d  = req_addr_q + 1'b1;
                        req_be_d    = la_be;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        rd_d        = req_we_q ? 32'd0 : extend_load(asm_merge, f3_q);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            a_q         <= '0;
            pc_q        <= '0;
            rd_q        <= '0;
            asm_q       <= '0;
            f3_q        <= '0;
            split_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            asm_q       <= asm_d;
            f3_q        <= f3_d;
            split_q     <= split_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = idle;
    assign req_valid = req_valid_q;
    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_be    = req_be_q;
    assign req_wdata = req_wdata_q;
    assign out_valid = out_valid_q;
    assign IR_out    = ir_q;
    assign RD_out    = rd_q;
    assign A_out     = a_q;
    assign PC_out    = pc_q;

endmodule

// File: tb/tb_load_store_initiator.sv
// Bench for load_store_initiator: directed cases plus randomized traffic
// against a byte-level memory model and a variable-latency responder.
module tb_load_store_initiator;

    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       IR, A, B, PC;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              out_valid;
    logic [31:0]       IR_out, RD_out, A_out, PC_out;

    load_store_initiator #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IR        (IR),
        .A         (A),
        .B         (B),
        .PC        (PC),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .out_valid (out_valid),
        .IR_out    (IR_out),
        .RD_out    (RD_out),
        .A_out     (A_out),
        .PC_out    (PC_out)
    );

    // ---------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // expected request beats: {we, word addr, be, wdata}
    logic [52:0] exp_q[$];
    logic [31:0] e_ir, e_a, e_pc, e_rd;

    // ---------------- memory model
    logic [31:0] mem [int];

    function automatic logic [31:0] mem_rd(input logic [15:0] w);
        if (mem.exists(int'(w))) return mem[int'(w)];
        return ({16'd0, w} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] addr);
        logic [31:0] w;
        w = mem_rd(addr[17:2]);
        return w[8*addr[1:0] +: 8];
    endfunction

    task automatic mem_wr(input logic [15:0] w, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] cur;
        cur = mem_rd(w);
        for (int k = 0; k < 4; k++) if (be[k]) cur[8*k +: 8] = d[8*k +: 8];
        mem[int'(w)] = cur;
    endtask

    // Reference: derive expected beats and writeback data byte by byte.
    task automatic model_issue(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        is_ld, is_st;
        int          n;
        logic [31:0] v, ba, wd;
        logic [15:0] w0;
        logic [3:0]  be0, be1;
        op    = ir[6:0];
        f3    = ir[14:12];
        is_ld = (op == 7'h03) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        is_st = (op == 7'h23) && (f3 <= 3'd2);
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e_ir  = ir;
        e_a   = a;
        e_pc  = pc;
        e_rd  = 32'd0;
        if (is_ld) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
                ba = a + i;
                v  = v | ({24'd0, byte_at(ba)} << (8 * i));
            end
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            e_rd = v;
        end
        if (is_ld || is_st) begin
            w0  = a[17:2];
            be0 = 4'd0;
            be1 = 4'd0;
            for (int i = 0; i < n; i++) begin
                ba = a + i;
                if (ba[17:2] == w0) be0[ba[1:0]] = 1'b1;
                else                be1[ba[1:0]] = 1'b1;
            end
            wd = 32'd0;
            for (int k = 0; k < 4; k++) wd[8*((int'(a[1:0]) + k) % 4) +: 8] = b[8*k +: 8];
            exp_q.push_back({is_st, w0, be0, wd});
            if (be1 != 4'd0) exp_q.push_back({is_st, w0 + 16'd1, be1, wd});
        end
    endtask

    // ---------------- memory responder
    bit          zero_wait   = 1'b1;
    int          stall_left  = 0;
    int          lat_override = -1;
    bit          pend        = 1'b0;
    int          pend_cnt    = 0;
    logic [31:0] pend_data;
    int          req_seen    = 0;
    int          rv_cycles   = 0;
    logic [15:0] last_addr, prev_addr;
    logic [3:0]  last_be, prev_be;
    logic [31:0] last_wdata, prev_wdata;

    always @(negedge clk) begin
        logic [52:0] e;
        rsp_valid = 1'b0;
        rsp_rdata = $urandom;
        if (pend) begin
            if (pend_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_rdata = pend_data;
                pend      = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (req_valid) rv_cycles++;
        if (stall_left > 0) begin
            req_ready = 1'b0;
            if (req_valid) stall_left--;
        end else if (zero_wait) begin
            req_ready = 1'b1;
        end else begin
            req_ready = ($urandom_range(0, 3) != 0);
        end
        if (rst_n && req_valid && req_ready) begin
            req_seen++;
            prev_addr  = last_addr;
            prev_be    = last_be;
            prev_wdata = last_wdata;
            last_addr  = req_addr;
            last_be    = req_be;
            last_wdata = req_wdata;
            check_eq("req_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("req_we", {31'd0, req_we}, {31'd0, e[52]});
                check_eq("req_addr", {16'd0, req_addr}, {16'd0, e[51:36]});
                check_eq("req_be", {28'd0, req_be}, {28'd0, e[35:32]});
                if (e[52]) check_eq("req_wdata", req_wdata, e[31:0]);
            end
            if (req_we) mem_wr(req_addr, req_be, req_wdata);
            pend      = 1'b1;
            pend_cnt  = (lat_override >= 0) ? lat_override : (zero_wait ? 0 : $urandom_range(0, 3));
            pend_data = req_we ? $urandom : mem_rd(req_addr);
        end
    end

    // ---------------- driver tasks (called just after a falling edge)
    task automatic start_instr(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc);
        int guard;
        model_issue(ir, a, b, pc);
        in_valid = 1'b1;
        IR = ir;
        A  = a;
        B  = b;
        PC = pc;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        IR = $urandom;
        A  = $urandom;
        B  = $urandom;
        PC = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_cyc > 0) check_eq({tag, "_latency"}, cyc, exp_cyc);
        check_eq({tag, "_ir"}, IR_out, e_ir);
        check_eq({tag, "_a"},  A_out,  e_a);
        check_eq({tag, "_pc"}, PC_out, e_pc);
        check_eq({tag, "_rd"}, RD_out, e_rd);
        @(negedge clk);
        check_eq({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_idle"},  {31'd0, in_ready},  32'd1);
    endtask

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[6:0]   = op;
        r[14:12] = f3;
        return r;
    endfunction

    // ---------------- main sequence
    initial begin
        int          n0, rv0, ov_seen, rv_seen;
        logic [15:0] s_addr;
        logic [3:0]  s_be;
        logic [31:0] s_wdata, ir, a, b;
        int          kind;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        IR = 32'd0; A = 32'd0; B = 32'd0; PC = 32'd0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_eq("rst_req_we",    {31'd0, req_we},    32'd0);
        check_eq("rst_req_addr",  {16'd0, req_addr},  32'd0);
        check_eq("rst_req_be",    {28'd0, req_be},    32'd0);
        check_eq("rst_req_wdata", req_wdata, 32'd0);
        check_eq("rst_ir_out",    IR_out, 32'd0);
        check_eq("rst_rd_out",    RD_out, 32'd0);
        check_eq("rst_a_out",     A_out,  32'd0);
        check_eq("rst_pc_out",    PC_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW aligned, zero-wait
        zero_wait = 1'b1;
        mem[32'h40] = 32'hDEADBEEF;
        start_instr(mk_ir(7'h03, 3'd2), 32'h100, $urandom, 32'h1000);
        wait_done("lw", 3);
        check_eq("lw_addr", {16'd0, last_addr}, 32'h40);
        check_eq("lw_be",   {28'd0, last_be},   32'hF);
        check_eq("lw_rd_lit", RD_out, 32'hDEADBEEF);

        // LB / LBU on the top lane
        mem[32'h40] = 32'h80AABBCC;
        start_instr(mk_ir(7'h03, 3'd0), 32'h103, $urandom, 32'h1004);
        wait_done("lb", 3);
        check_eq("lb_be", {28'd0, last_be}, 32'h8);
        check_eq("lb_rd_lit", RD_out, 32'hFFFFFF80);
        start_instr(mk_ir(7'h03, 3'd4), 32'h103, $urandom, 32'h1008);
        wait_done("lbu", 3);
        check_eq("lbu_rd_lit", RD_out, 32'h00000080);

        // SW split across two words
        start_instr(mk_ir(7'h23, 3'd2), 32'h102, 32'h11223344, 32'h100C);
        wait_done("sw", 5);
        check_eq("sw_b0_addr",  {16'd0, prev_addr}, 32'h40);
        check_eq("sw_b0_be",    {28'd0, prev_be},   32'hC);
        check_eq("sw_b0_wdata", prev_wdata, 32'h33441122);
        check_eq("sw_b1_addr",  {16'd0, last_addr}, 32'h41);
        check_eq("sw_b1_be",    {28'd0, last_be},   32'h3);
        check_eq("sw_b1_wdata", last_wdata, 32'h33441122);

        // LH wrapping the word index
        mem[32'hFFFF] = 32'h7F000000;
        mem[32'h0000] = 32'h00000001;
        start_instr(mk_ir(7'h03, 3'd1), 32'h3FFFF, $urandom, 32'h1010);
        wait_done("lh_wrap", 5);
        check_eq("lh_wrap_b1_addr", {16'd0, last_addr}, 32'h0);
        check_eq("lh_wrap_b1_be",   {28'd0, last_be},   32'h1);
        check_eq("lh_wrap_rd_lit",  RD_out, 32'h0000017F);

        // non-memory op: no bus traffic
        n0  = req_seen;
        rv0 = rv_cycles;
        start_instr(mk_ir(7'h33, 3'd0), 32'h104, $urandom, 32'h1014);
        wait_done("add", 1);
        check_eq("add_no_req", req_seen - n0, 0);
        check_eq("add_no_req_valid", rv_cycles - rv0, 0);

        // request held while req_ready stays low
        stall_left = 5;
        start_instr(mk_ir(7'h23, 3'd1), 32'h201, $urandom, 32'h1018);
        s_addr  = req_addr;
        s_be    = req_be;
        s_wdata = req_wdata;
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_valid", {31'd0, req_valid}, 32'd1);
            check_eq("stall_addr",  {16'd0, req_addr}, {16'd0, s_addr});
            check_eq("stall_be",    {28'd0, req_be},   {28'd0, s_be});
            check_eq("stall_wdata", req_wdata, s_wdata);
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        wait_done("stall", 0);

        // reset while waiting for a load response, then a stray response
        lat_override = 10;
        start_instr(mk_ir(7'h03, 3'd2), 32'h300, $urandom, 32'h101C);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req_valid", {31'd0, req_valid}, 32'd0);
        check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        ov_seen = 0;
        rv_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
            if (req_valid) rv_seen++;
        end
        check_eq("stray_rsp_no_out", ov_seen, 0);
        check_eq("stray_rsp_no_req", rv_seen, 0);
        lat_override = -1;

        // randomized traffic with variable latency and backpressure
        zero_wait = 1'b0;
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       a = 32'h100 + $urandom_range(0, 31);
                1:       a = 32'h3FFE0 + $urandom_range(0, 31);
                default: a = $urandom;
            endcase
            b = $urandom;
            if (kind <= 4) begin
                ir = mk_ir(7'h03, 3'($urandom_range(0, 7)));
            end else if (kind <= 7) begin
                ir = mk_ir(7'h23, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7))
                                                              : 3'($urandom_range(0, 2)));
            end else if (kind == 8) begin
                ir = mk_ir(7'h33, 3'($urandom_range(0, 7)));
            end else begin
                ir = $urandom;
            end
            start_instr(ir, a, b, $urandom);
            wait_done("rand", 0);
        end

        check_eq("req_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
